// File: rtl/escritura_memoria_to_registro_pkg.sv
// Shared address map, sizes and FSM encoding for the processor-to-network write port.
package escritura_memoria_to_registro_pkg;

  localparam logic [8:0] ADDR_CTRL    = 9'h000;
  localparam logic [8:0] ADDR_ERR     = 9'h008;
  localparam logic [8:0] ADDR_COEFF0  = 9'h00C;
  localparam logic [8:0] ADDR_OFFSET  = 9'h05C;
  localparam logic [8:0] ADDR_ENTRADA = 9'h060;

  localparam int unsigned NUM_COEFF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Byte address of coefficient k; word stride keeps bits[1:0] zero.
  function automatic logic [8:0] coeff_addr(input int unsigned k);
    return ADDR_COEFF0 + 9'(k << 2);
  endfunction

endpackage

// File: rtl/escritura_memoria_to_registro_if.sv
// Write-bus and network-facing signals of the write port, grouped with master/slave views.
interface escritura_memoria_to_registro_if #(
  parameter int Width = 4
);
  import escritura_memoria_to_registro_pkg::*;

  logic                          Write;
  logic [8:0]                    Address;
  logic signed [Width-1:0]       InDato;
  logic                          ListoIn;
  logic [NUM_COEFF*Width-1:0]    CoeffBus;
  logic signed [Width-1:0]       OffsetOut;
  logic signed [Width-1:0]       DatoEntrada;
  logic                          Iniciar;
  logic                          Ocupado;
  logic                          InError;
  logic                          Timeout;

  modport master (
    output Write, Address, InDato, ListoIn,
    input  CoeffBus, OffsetOut, DatoEntrada, Iniciar, Ocupado, InError, Timeout
  );

  modport slave (
    input  Write, Address, InDato, ListoIn,
    output CoeffBus, OffsetOut, DatoEntrada, Iniciar, Ocupado, InError, Timeout
  );

endinterface

// File: rtl/escritura_memoria_to_registro_shadow_bank.sv
// Shadow registers loaded by decoded writes, copied to the active set on commit.
module escritura_memoria_to_registro_shadow_bank
  import escritura_memoria_to_registro_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_write,
  input  logic [8:0]                 i_addr,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_commit,
  output logic [NUM_COEFF*Width-1:0] o_coeff_bus,
  output logic [Width-1:0]           o_offset,
  output logic [Width-1:0]           o_entrada
);

  logic [Width-1:0] r_sh_coeff  [NUM_COEFF];
  logic [Width-1:0] r_act_coeff [NUM_COEFF];
  logic [Width-1:0] r_sh_offset, r_act_offset;
  logic [Width-1:0] r_sh_entrada, r_act_entrada;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_COEFF; k++) begin
        r_sh_coeff[k]  <= '0;
        r_act_coeff[k] <= '0;
      end
      r_sh_offset   <= '0;
      r_act_offset  <= '0;
      r_sh_entrada  <= '0;
      r_act_entrada <= '0;
    end else begin
      if (i_write) begin
        for (int unsigned k = 0; k < NUM_COEFF; k++) begin
          if (i_addr == coeff_addr(k)) r_sh_coeff[k] <= i_data;
        end
        if (i_addr == ADDR_OFFSET)  r_sh_offset  <= i_data;
        if (i_addr == ADDR_ENTRADA) r_sh_entrada <= i_data;
      end
      // Commit only coincides with a control write, so shadows are never updated on that edge.
      if (i_commit) begin
        for (int unsigned k = 0; k < NUM_COEFF; k++) r_act_coeff[k] <= r_sh_coeff[k];
        r_act_offset  <= r_sh_offset;
        r_act_entrada <= r_sh_entrada;
      end
    end
  end

  always_comb begin
    o_coeff_bus = '0;
    for (int unsigned k = 0; k < NUM_COEFF; k++) o_coeff_bus[k*Width +: Width] = r_act_coeff[k];
  end

  assign o_offset  = r_act_offset;
  assign o_entrada = r_act_entrada;

endmodule

// File: rtl/escritura_memoria_to_registro.sv
// Memory-mapped write port: shadow/active parameter registers, start handshake and timeout/error flags.
module escritura_memoria_to_registro
  import escritura_memoria_to_registro_pkg::*;
#(
  parameter int Width      = 4,
  parameter int TimeoutCyc = 1024
) (
  input logic CLK,
  input logic RST,
  escritura_memoria_to_registro_if.slave bus
);

  localparam int CntW = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);

  state_t          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_inerror, r_timeout;
  logic            w_start_cmd, w_clear_cmd;
  logic            w_commit, w_iniciar, w_ocupado, w_busy_err, w_timeout_evt;

  assign w_start_cmd = bus.Write && (bus.Address == ADDR_CTRL) && (bus.InDato != '0);
  assign w_clear_cmd = bus.Write && (bus.Address == ADDR_ERR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_inerror <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // A new error event on the same edge as a clear keeps the flag set.
      if (w_busy_err || w_timeout_evt) r_inerror <= 1'b1;
      else if (w_clear_cmd)            r_inerror <= 1'b0;
      if (w_timeout_evt)               r_timeout <= 1'b1;
      else if (w_clear_cmd)            r_timeout <= 1'b0;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_commit      = 1'b0;
    w_iniciar     = 1'b0;
    w_ocupado     = 1'b0;
    w_busy_err    = 1'b0;
    w_timeout_evt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_cmd) begin
          w_state_next = ST_START;
          w_commit     = 1'b1;
        end
      end
      ST_START: begin
        w_iniciar    = 1'b1;
        w_ocupado    = 1'b1;
        w_busy_err   = w_start_cmd;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_ocupado  = 1'b1;
        w_busy_err = w_start_cmd;
        if (bus.ListoIn) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == CntLast) begin
          w_state_next  = ST_IDLE;
          w_timeout_evt = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic [NUM_COEFF*Width-1:0] w_coeff_bus;
  logic [Width-1:0]           w_offset, w_entrada;

  escritura_memoria_to_registro_shadow_bank #(
    .Width(Width)
  ) u_shadow_bank (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_write     (bus.Write),
    .i_addr      (bus.Address),
    .i_data      (bus.InDato),
    .i_commit    (w_commit),
    .o_coeff_bus (w_coeff_bus),
    .o_offset    (w_offset),
    .o_entrada   (w_entrada)
  );

  assign bus.CoeffBus    = w_coeff_bus;
  assign bus.OffsetOut   = w_offset;
  assign bus.DatoEntrada = w_entrada;
  assign bus.Iniciar     = w_iniciar;
  assign bus.Ocupado     = w_ocupado;
  assign bus.InError     = r_inerror;
  assign bus.Timeout     = r_timeout;

endmodule

// File: tb/tb_escritura_memoria_to_registro.sv
// Directed bench for the write port: expected output snapshots are queued per step and checked after each edge.
module tb_escritura_memoria_to_registro;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  escritura_memoria_to_registro_if #(.Width(W)) bus ();

  escritura_memoria_to_registro #(
    .Width      (W),
    .TimeoutCyc (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] c0, c19, off, ent;
    logic       ini, ocu, err, to;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [8:0] a, input logic [3:0] d, input logic li);
    bus.Write   = wr;
    bus.Address = a;
    bus.InDato  = d;
    bus.ListoIn = li;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c0, input logic [3:0] c19,
                            input logic [3:0] off, input logic [3:0] ent,
                            input logic ini, input logic ocu, input logic err, input logic to);
    exp_t e;
    e.tag = tag; e.c0 = c0; e.c19 = c19; e.off = off; e.ent = ent;
    e.ini = ini; e.ocu = ocu; e.err = err; e.to = to;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk();
    exp_t e;
    tick();
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".c0"},  bus.CoeffBus[3:0],   e.c0);
      chk({e.tag, ".c19"}, bus.CoeffBus[79:76], e.c19);
      chk({e.tag, ".off"}, bus.OffsetOut,       e.off);
      chk({e.tag, ".ent"}, bus.DatoEntrada,     e.ent);
      chk({e.tag, ".ini"}, {3'b0, bus.Iniciar}, {3'b0, e.ini});
      chk({e.tag, ".ocu"}, {3'b0, bus.Ocupado}, {3'b0, e.ocu});
      chk({e.tag, ".err"}, {3'b0, bus.InError}, {3'b0, e.err});
      chk({e.tag, ".to"},  {3'b0, bus.Timeout}, {3'b0, e.to});
    end
  endtask

  initial begin
    drive(1'b0, 9'h000, 4'h0, 1'b0);

    // Reset state
    expect_out("reset", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0); tick_chk();
    rst = 1'b0;

    // 1: load shadows, start, check commit latency and single Iniciar
    drive(1'b1, 9'h00C, 4'h3, 1'b0); tick();
    drive(1'b1, 9'h058, 4'hE, 1'b0); tick();
    drive(1'b1, 9'h05C, 4'h1, 1'b0); tick();
    drive(1'b1, 9'h060, 4'h5, 1'b0);
    expect_out("pre_start", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h000, 4'h1, 1'b0);
    expect_out("t1_start", 4'h3, 4'hE, 4'h1, 4'h5, 1, 1, 0, 0); tick_chk();
    drive(1'b0, 9'h000, 4'h0, 1'b0);
    expect_out("t1_wait", 4'h3, 4'hE, 4'h1, 4'h5, 0, 1, 0, 0); tick_chk();

    // 2: shadow write while busy leaves active frozen
    drive(1'b1, 9'h00C, 4'h7, 1'b0);
    expect_out("t2_frozen", 4'h3, 4'hE, 4'h1, 4'h5, 0, 1, 0, 0); tick_chk();

    // 3: start while busy -> error, no Iniciar; then clear
    drive(1'b1, 9'h000, 4'h1, 1'b0);
    expect_out("t3_busy_start", 4'h3, 4'hE, 4'h1, 4'h5, 0, 1, 1, 0); tick_chk();
    drive(1'b1, 9'h008, 4'h0, 1'b0);
    expect_out("t3_clear", 4'h3, 4'hE, 4'h1, 4'h5, 0, 1, 0, 0); tick_chk();
    drive(1'b0, 9'h000, 4'h0, 1'b1);
    expect_out("t3_listo", 4'h3, 4'hE, 4'h1, 4'h5, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h000, 4'h0, 1'b0);
    expect_out("t3_zero_start", 4'h3, 4'hE, 4'h1, 4'h5, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h000, 4'h1, 1'b0);
    expect_out("t2_restart", 4'h7, 4'hE, 4'h1, 4'h5, 1, 1, 0, 0); tick_chk();

    // 4: timeout after 8 WAIT cycles
    drive(1'b0, 9'h000, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    expect_out("t4_last_wait", 4'h7, 4'hE, 4'h1, 4'h5, 0, 1, 0, 0); tick_chk();
    expect_out("t4_timeout", 4'h7, 4'hE, 4'h1, 4'h5, 0, 0, 1, 1); tick_chk();

    // 5: ListoIn on the final WAIT cycle wins
    drive(1'b1, 9'h008, 4'h3, 1'b0);
    expect_out("t5_clear", 4'h7, 4'hE, 4'h1, 4'h5, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h000, 4'h1, 1'b0);
    expect_out("t5_start", 4'h7, 4'hE, 4'h1, 4'h5, 1, 1, 0, 0); tick_chk();
    drive(1'b0, 9'h000, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    expect_out("t5_pre", 4'h7, 4'hE, 4'h1, 4'h5, 0, 1, 0, 0); tick_chk();
    drive(1'b0, 9'h000, 4'h0, 1'b1);
    expect_out("t5_listo_last", 4'h7, 4'hE, 4'h1, 4'h5, 0, 0, 0, 0); tick_chk();

    // 6: reset mid-run clears everything; stray/unaligned writes have no effect
    drive(1'b1, 9'h000, 4'h8, 1'b0);
    expect_out("t6_start", 4'h7, 4'hE, 4'h1, 4'h5, 1, 1, 0, 0); tick_chk();
    drive(1'b1, 9'h05C, 4'h3, 1'b0); tick();
    drive(1'b0, 9'h000, 4'h0, 1'b0);
    rst = 1'b1;
    expect_out("t6_reset", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0); tick_chk();
    rst = 1'b0;
    drive(1'b1, 9'h0A0, 4'h5, 1'b0);
    expect_out("t6_stray", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h00D, 4'h5, 1'b0);
    expect_out("t6_unaligned", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0); tick_chk();
    drive(1'b1, 9'h000, 4'h1, 1'b0);
    expect_out("t6_start_clean", 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0); tick_chk();

    // Same-edge clear and timeout: error flags stay set
    drive(1'b0, 9'h000, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    expect_out("clr_pre", 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0); tick_chk();
    drive(1'b1, 9'h008, 4'h0, 1'b0);
    expect_out("clr_vs_timeout", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1); tick_chk();
    drive(1'b0, 9'h000, 4'h0, 1'b0);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
